// File: rtl/at86rf215_iq_deframer.sv
// at86rf215_iq_deframer: finds the 32-bit I/Q word boundary in the RX pair stream, tracks lock
// and emits one 13-bit I/Q sample pair per word with sync-error reporting.
module at86rf215_iq_deframer #(
  parameter int LOCK_COUNT = 2,
  parameter int LOSS_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pair_in,
  input  logic        pair_valid,
  input  logic        clr_err,
  output logic [12:0] i_out,
  output logic [12:0] q_out,
  output logic        ctrl_out,
  output logic        sample_valid,
  output logic        sync_err,
  output logic        locked,
  output logic [15:0] err_count
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state, state_n;
  // only the low 31 bits of the stored history ever reach the 33-bit post-shift window
  logic [30:0] sr;
  logic [32:0] nsr;
  logic [26:0] wn;
  logic [3:0] cnt, cnt_n, good, good_n, miss, miss_n;
  logic pend, pend_n, phase, phase_n, m0, m1, mp, hit, take, err;
  assign nsr = {sr, pair_in};
  assign m0 = nsr[31:30] == 2'b10 && nsr[15:14] == 2'b01 && !nsr[0];
  assign m1 = nsr[32:31] == 2'b10 && nsr[16:15] == 2'b01 && !nsr[1];
  assign mp = phase ? m1 : m0;
  assign wn = phase_n ? {nsr[30:17], nsr[14:2]} : {nsr[29:16], nsr[13:1]};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    good_n = good;
    miss_n = miss;
    pend_n = pend;
    phase_n = phase;
    hit = 1'b0;
    take = 1'b0;
    err = 1'b0;
    if (pair_valid) begin
      cnt_n = cnt + 4'd1;
      if (state == LOCKED) begin
        if (cnt == 4'd15) begin
          take = mp;
          err = !mp;
          miss_n = mp ? 4'd0 : miss + 4'd1;
          if (!mp && miss_n == 4'(LOSS_COUNT)) begin
            state_n = HUNT;
            cnt_n = 4'd0;
            good_n = 4'd0;
            miss_n = 4'd0;
            pend_n = 1'b0;
          end
        end
      end else if (!pend || cnt == 4'd15) begin
        if (pend && mp) begin
          good_n = good + 4'd1;
          hit = 1'b1;
        end else if (m0 || m1) begin
          pend_n = 1'b1;
          phase_n = !m0;
          good_n = 4'd1;
          cnt_n = 4'd0;
          hit = 1'b1;
        end else begin
          pend_n = 1'b0;
          good_n = 4'd0;
          cnt_n = 4'd0;
        end
        if (hit && good_n == 4'(LOCK_COUNT)) begin
          state_n = LOCKED;
          take = 1'b1;
          miss_n = 4'd0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      sr <= '0;
      cnt <= '0;
      good <= '0;
      miss <= '0;
      pend <= 1'b0;
      phase <= 1'b0;
      i_out <= '0;
      q_out <= '0;
      ctrl_out <= 1'b0;
      sample_valid <= 1'b0;
      sync_err <= 1'b0;
      locked <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      sr <= pair_valid ? nsr[30:0] : sr;
      cnt <= cnt_n;
      good <= good_n;
      miss <= miss_n;
      pend <= pend_n;
      phase <= phase_n;
      sample_valid <= take;
      sync_err <= err;
      locked <= state_n == LOCKED;
      if (take) begin
        i_out <= wn[26:14];
        ctrl_out <= wn[13];
        q_out <= wn[12:0];
      end
      err_count <= clr_err ? 16'd0 : (err && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    end
  end
endmodule

// File: tb/tb_at86rf215_iq_deframer.sv
// tb_at86rf215_iq_deframer: word-table scenarios plus randomized streams checked cycle by cycle
// against a bit-queue reference model of the deframer.
module tb_at86rf215_iq_deframer;
  localparam int LOCK = 2;
  localparam int LOSS = 3;
  localparam logic [12:0] A_I = 13'h0FFF, A_Q = 13'h1000, B_I = 13'h1FFF, B_Q = 13'h0001;

  logic clk = 0, rst_n = 1;
  logic [1:0] pair_in = 0;
  logic pair_valid = 0, clr_err = 0;
  logic [12:0] i_out, q_out;
  logic ctrl_out, sample_valid, sync_err, locked;
  logic [15:0] err_count;
  int checks = 0, fails = 0, se_seen = 0;
  bit txq[$];
  logic [12:0] got_i[$];

  bit hist[$];
  int n, anchor, m_good, m_miss;
  bit m_lk, m_pend, m_ph;
  logic [12:0] m_i, m_q;
  logic m_c, m_sv, m_se;
  logic [15:0] m_ec;

  typedef struct {
    logic [12:0] i, q;
    logic c, bad, cf, cl, ev, ee, el;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  at86rf215_iq_deframer #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .pair_in(pair_in), .pair_valid(pair_valid), .clr_err(clr_err),
    .i_out(i_out), .q_out(q_out), .ctrl_out(ctrl_out), .sample_valid(sample_valid),
    .sync_err(sync_err), .locked(locked), .err_count(err_count)
  );

  function automatic logic [45:0] outs();
    return {i_out, q_out, ctrl_out, sample_valid, sync_err, locked, err_count};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] win(input int ph);
    logic [31:0] w;
    for (int k = 0; k < 32; k++) w[k] = hist[hist.size() - 1 - ph - k];
    return w;
  endfunction

  function automatic bit match(input logic [31:0] w);
    return w[31:30] == 2'b10 && w[15:14] == 2'b01 && w[0] == 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (33) hist.push_back(1'b0);
    n = 0; anchor = 0; m_good = 0; m_miss = 0;
    m_lk = 0; m_pend = 0; m_ph = 0;
    m_i = 0; m_q = 0; m_c = 0; m_sv = 0; m_se = 0; m_ec = 0;
  endtask

  task automatic model_take();
    logic [31:0] w;
    w = win(int'(m_ph));
    m_sv = 1;
    m_i = w[29:17];
    m_c = w[16];
    m_q = w[13:1];
  endtask

  // boundaries are every 16th valid pair counted from the anchor pair of the current alignment
  task automatic model_step(input logic [1:0] p, input logic v, input logic clr);
    bit on_bnd, hit;
    m_sv = 0;
    m_se = 0;
    if (v) begin
      hist.push_back(p[1]);
      hist.push_back(p[0]);
      void'(hist.pop_front());
      void'(hist.pop_front());
      n++;
      on_bnd = ((n - anchor) % 16) == 0;
      if (m_lk) begin
        if (on_bnd) begin
          if (match(win(int'(m_ph)))) begin
            model_take();
            m_miss = 0;
          end else begin
            m_se = 1;
            m_miss++;
            if (m_miss == LOSS) begin
              m_lk = 0; m_pend = 0; m_miss = 0; m_good = 0;
            end
          end
        end
      end else begin
        hit = 0;
        if (m_pend && on_bnd) begin
          if (match(win(int'(m_ph)))) begin m_good++; hit = 1; end
          else m_pend = 0;
        end
        if (!m_pend && (match(win(0)) || match(win(1)))) begin
          m_pend = 1;
          m_ph = match(win(0)) ? 1'b0 : 1'b1;
          anchor = n;
          m_good = 1;
          hit = 1;
        end
        if (hit && m_good >= LOCK) begin
          m_lk = 1; m_miss = 0; anchor = n;
          model_take();
        end
      end
    end
    if (clr) m_ec = 0;
    else if (m_se && m_ec != 16'hFFFF) m_ec++;
  endtask

  task automatic step(input logic [1:0] p, input logic v, input logic clr);
    pair_in = p;
    pair_valid = v;
    clr_err = clr;
    @(posedge clk);
    model_step(p, v, clr);
    #1;
    chk("cycle", 64'(outs()), 64'({m_i, m_q, m_c, m_sv, m_se, m_lk, m_ec}));
    chk("sv_se_exclusive", 64'(sample_valid & sync_err), 64'd0);
    if (sample_valid) got_i.push_back(i_out);
    if (sync_err) se_seen++;
    clr_err = 0;
  endtask

  task automatic push_word(input logic [12:0] i, input logic [12:0] q, input logic c, input logic bad);
    logic [31:0] w;
    w = {bad ? 2'b11 : 2'b10, i, c, 2'b01, q, 1'b0};
    for (int k = 31; k >= 0; k--) txq.push_back(w[k]);
  endtask

  task automatic emit(input int gmax, input logic cf, input logic cl, input int maxp);
    bit b1, b0, first;
    int cnt;
    first = 1;
    cnt = 0;
    while (txq.size() >= 2 && cnt != maxp) begin
      repeat ($urandom_range(0, gmax)) step(2'($urandom), 1'b0, 1'b0);
      b1 = txq.pop_front();
      b0 = txq.pop_front();
      step({b1, b0}, 1'b1, (cf && first) || (cl && txq.size() < 2));
      first = 0;
      cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    pair_valid = 0;
    clr_err = 0;
    #2;
    model_reset();
    chk("async_reset_outputs", 64'(outs()), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{A_I, A_Q, 1'b1, 0, 0, 0, 0, 0, 0, 16'd0};
    tbl[1]  = '{B_I, B_Q, 1'b0, 0, 0, 0, 1, 0, 1, 16'd0};
    tbl[2]  = '{A_I, A_Q, 1'b1, 0, 0, 0, 1, 0, 1, 16'd0};
    tbl[3]  = '{B_I, B_Q, 1'b0, 0, 0, 0, 1, 0, 1, 16'd0};
    tbl[4]  = '{A_I, A_Q, 1'b1, 1, 0, 0, 0, 1, 1, 16'd1};
    tbl[5]  = '{B_I, B_Q, 1'b0, 0, 0, 0, 1, 0, 1, 16'd1};
    tbl[6]  = '{A_I, A_Q, 1'b1, 1, 1, 0, 0, 1, 1, 16'd1};
    tbl[7]  = '{B_I, B_Q, 1'b0, 1, 0, 0, 0, 1, 1, 16'd2};
    tbl[8]  = '{A_I, A_Q, 1'b1, 1, 0, 0, 0, 1, 0, 16'd3};
    tbl[9]  = '{B_I, B_Q, 1'b0, 0, 0, 0, 0, 0, 0, 16'd3};
    tbl[10] = '{A_I, A_Q, 1'b1, 0, 0, 0, 1, 0, 1, 16'd3};
    tbl[11] = '{B_I, B_Q, 1'b0, 0, 0, 0, 1, 0, 1, 16'd3};
    tbl[12] = '{A_I, A_Q, 1'b1, 1, 0, 1, 0, 1, 1, 16'd0};
    #1;
    do_reset();
    for (int r = 0; r < 13; r++) begin
      push_word(tbl[r].i, tbl[r].q, tbl[r].c, tbl[r].bad);
      emit(0, tbl[r].cf, tbl[r].cl, -1);
      chk($sformatf("row%0d_flags", r), 64'({sample_valid, sync_err, locked, err_count}),
          64'({tbl[r].ev, tbl[r].ee, tbl[r].el, tbl[r].ec}));
      if (tbl[r].ev) chk($sformatf("row%0d_data", r), 64'({i_out, ctrl_out, q_out}),
                         64'({tbl[r].i, tbl[r].c, tbl[r].q}));
    end

    do_reset();
    got_i.delete();
    txq.push_back(1'b0);
    for (int k = 0; k < 5; k++) push_word(k % 2 ? B_I : A_I, k % 2 ? B_Q : A_Q, k % 2 == 0, 1'b0);
    txq.push_back(1'b0);
    emit(0, 1'b0, 1'b0, -1);
    chk("ph1_samples", 64'(got_i.size()), 64'd4);
    for (int k = 0; k < 4 && k < got_i.size(); k++)
      chk($sformatf("ph1_i%0d", k), 64'(got_i[k]), 64'(k % 2 ? A_I : B_I));
    chk("ph1_phase", 64'(dut.phase), 64'd1);
    chk("ph1_locked", 64'(locked), 64'd1);

    do_reset();
    got_i.delete();
    se_seen = 0;
    for (int k = 0; k < 6; k++) push_word(k % 2 ? B_I : A_I, k % 2 ? B_Q : A_Q, k % 2 == 0, 1'b0);
    emit(3, 1'b0, 1'b0, -1);
    chk("gap_samples", 64'(got_i.size()), 64'd5);
    for (int k = 0; k < 5 && k < got_i.size(); k++)
      chk($sformatf("gap_i%0d", k), 64'(got_i[k]), 64'(k % 2 ? A_I : B_I));
    chk("gap_no_sync_err", 64'(se_seen), 64'd0);

    push_word(A_I, A_Q, 1'b1, 1'b0);
    emit(0, 1'b0, 1'b0, 7);
    do_reset();
    emit(0, 1'b0, 1'b0, -1);
    chk("rst_tail_unlocked", 64'({sample_valid, locked}), 64'd0);
    push_word(B_I, B_Q, 1'b0, 1'b0);
    emit(0, 1'b0, 1'b0, -1);
    chk("rst_word1_unlocked", 64'({sample_valid, locked}), 64'd0);
    push_word(A_I, A_Q, 1'b1, 1'b0);
    emit(0, 1'b0, 1'b0, -1);
    chk("rst_word2_locked", 64'({sample_valid, locked, i_out}), 64'({2'b11, A_I}));

    do_reset();
    for (int k = 0; k < 60; k++) begin
      push_word(13'($urandom), 13'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
      emit($urandom_range(0, 2), 1'b0, $urandom_range(0, 15) == 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
